mux_sel_arbiter: RTL

Round-robin arbiter that drives the 2-bit select of the 4:1 channel mux stage directly downstream. It takes four request lines, grants one channel at a time and presents the winner as `sel` plus a one-hot `grant`. It holds the grant for a burst of up to `BURST_LEN` accepted transfers under a valid/ready handshake with the consumer of the mux output. Priority then rotates so no channel starves.

---
 rtl/mux_sel_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: round-robin arbiter for a 4:1 channel mux.
// Grants one requesting channel at a time and holds it for up to
// BURST_LEN accepted transfers. A transfer is a cycle with
// out_valid=1 and out_ready=1. out_valid is asserted whenever a grant
// is held, and it does not depend on out_ready. The consumer may hold
// out_ready low for any length of time. While it does so, the grant,
// sel and beat remain frozen.
// At release, priority rotates to the channel after the released one.
module mux_sel_arbiter #(
    parameter int BURST_LEN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       out_ready,
    output logic [1:0] sel,
    output logic [3:0] grant,
    output logic       out_valid,
    output logic [7:0] beat
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

    state_t     state, state_next;
    logic [1:0] ptr, ptr_next;
    logic [1:0] sel_next;
    logic [3:0] grant_next;
    logic       valid_next;
    logic [7:0] beat_next;

    logic [1:0] search_base;
    logic [1:0] win_idx;
    logic       any_req;
    logic       xfer;
    logic       release_now;

    // The search starts at ptr when idle. At a release it starts one past
    // the released channel, because ptr is updated in that same cycle.
    always_comb begin
        search_base = (state == GRANT) ? sel + 2'd1 : ptr;
        any_req     = |req;
        xfer        = (state == GRANT) && out_ready;
        release_now = xfer && ((beat == LAST_BEAT) || !req[sel]);
    end

    // Round-robin winner search. Offsets are scanned from highest to lowest,
    // so the lowest offset from search_base is the one left assigned.
    always_comb begin
        win_idx = search_base;
        for (int i = 3; i >= 0; i--) begin
            if (req[search_base + 2'(i)]) begin
                win_idx = search_base + 2'(i);
            end
        end
    end

    // Next-state and next-output logic. By default every register holds its value.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        sel_next   = sel;
        grant_next = grant;
        valid_next = out_valid;
        beat_next  = beat;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = GRANT;
                    sel_next   = win_idx;
                    grant_next = 4'b0001 << win_idx;
                    valid_next = 1'b1;
                    beat_next  = 8'd0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    ptr_next  = sel + 2'd1;
                    beat_next = 8'd0;
                    if (any_req) begin
                        sel_next   = win_idx;
                        grant_next = 4'b0001 << win_idx;
                    end else begin
                        state_next = IDLE;
                        grant_next = 4'b0000;
                        valid_next = 1'b0;
                    end
                end else if (xfer) begin
                    beat_next = beat + 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = 4'b0000;
                valid_next = 1'b0;
                beat_next  = 8'd0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            sel       <= 2'd0;
            grant     <= 4'b0000;
            out_valid <= 1'b0;
            beat      <= 8'd0;
        end else begin
            state     <= state_next;
            ptr       <= ptr_next;
            sel       <= sel_next;
            grant     <= grant_next;
            out_valid <= valid_next;
            beat      <= beat_next;
        end
    end

endmodule
